mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ALUCTL_W, default 3, ALUControl width; legal values 3..4, with upper bits zero-filled.
REQ-002 Parameter STATE_W, default 4, state register width; legal value 4 or greater.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Instr  in  32  current instruction register contents; bits [7:4] are used for MUL detection.
REQ-006 ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in execute states.
REQ-007 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA  out  1 each  datapath strobes and selects.
REQ-008 RegSrc, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath selects.
REQ-009 ALUControl  out  ALUCTL_W  ALU operation code.
REQ-010 LinkWrite  out  1  forces the register-file write address to R14 (BL).
REQ-011 State  out  STATE_W  current FSM state, for debug and bench only.

Function
REQ-012 The FSM SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, LINK, plus EXECM when the multiply feature is compiled in.
REQ-013 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR when Op=01.
- DECODE->EXECR when Op=00 and I=0.
- DECODE->EXECI when Op=00 and I=1.
- DECODE->BRANCH when Op=10.
- Op=11 (undefined) SHALL return to FETCH.
REQ-014 Memory path: MEMADR->MEMRD when L=1, else MEMWR; MEMRD->MEMWB->FETCH; MEMWR->FETCH.
REQ-015 Data-processing path: EXECR/EXECI->ALUWB->FETCH.
REQ-016 Branch path: BRANCH->LINK when Instr[24]=1 (BL), else FETCH; LINK->FETCH.
REQ-017 FETCH SHALL assert IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD, and PCWrite=1 unconditionally.
REQ-018 The condition code Instr[31:28] SHALL be evaluated in DECODE against the flag register and registered as CondEx; CondEx gates every later RegWrite, MemWrite, PCWrite and flag update of that instruction.
REQ-019 The flag register SHALL update at the end of EXECR/EXECI/EXECM only when CondEx=1 and S=1:
- {N,Z} are always written;
- {C,V} are written only for arithmetic ops (ADD, SUB, CMP).
REQ-020 ALUControl encoding: ADD=000, SUB=001, AND=010, ORR=011, EOR=100, MUL=101.
REQ-021 cmd mapping: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 CMP (SUB, S forced 1, no register write); any other cmd SHALL decode as ADD with RegWrite suppressed.
REQ-022 If Rd=15 on a data-processing or LDR writeback, the write SHALL target PC (PCWrite=CondEx) instead of RegWrite.
REQ-023 LINK SHALL write the old PC+4 to R14 via LinkWrite=1 and RegWrite=CondEx, using the PC value held before BRANCH updated it.
REQ-024 Outputs SHALL be a pure function of State, Instr and CondEx; no output glitches across states matter beyond the cycle boundary.

Reset
REQ-025 When reset=1 at a clock edge:
- State SHALL become FETCH;
- the flag register SHALL become 0000;
- CondEx SHALL become 0.
REQ-026 During reset all write strobes (PCWrite, MemWrite, RegWrite, IRWrite) SHALL be 0.
REQ-027 After reset, the first FETCH cycle SHALL behave as in REQ-017.
REQ-028 Reset asserted in any state SHALL abort the instruction with no register or memory write in that cycle.

Configuration
REQ-029 Macro MC_CTRL_MUL_EN, when defined, enables MUL: Op=00, I=0, cmd=0000, Instr[7:4]=1001 routes DECODE->EXECM->ALUWB with ALUControl=MUL.
REQ-030 Without MC_CTRL_MUL_EN that encoding SHALL decode as AND, and state EXECM SHALL not exist.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the ALUControl codes, the cmd codes and the condition-code constants.
REQ-032 Condition evaluation (flag register, CondEx, and the 15-code condition check) SHALL be one sub-module, mc_condunit; the FSM and decode remain in mc_controller.

Verification
REQ-033 Reset pulse then ADD R1,R2,R3 (0xE0821003) -> states FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; ALUControl=000.
REQ-034 CMP R1,R1 (0xE1510001) with ALUFlags=0110 in EXECR -> next state ALUWB with RegWrite=0; flags register reads 0110.
REQ-035 BEQ with flags Z=0 -> PCWrite=0 in BRANCH; with Z=1 -> PCWrite=1.
REQ-036 BL (0xEB000004) -> BRANCH then LINK; LinkWrite=1 and RegWrite=1 in LINK only.
REQ-037 LDR R0,[R1] (0xE5910000) -> MEMADR,MEMRD,MEMWB; STR (0xE5810000) -> MEMADR,MEMWR with MemWrite=1 for exactly one cycle.
REQ-038 With MC_CTRL_MUL_EN, 0xE0000291 -> EXECM with ALUControl=101; reset asserted in EXECM -> next state FETCH, RegWrite stays 0.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - state, ALU, cmd and condition constants (MC_CTRL_MUL_EN adds EXECM)
package mc_controller_pkg;

   // FSM state encodings
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXECR  = 4'd6;
   localparam logic [3:0] S_EXECI  = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_LINK   = 4'd10;
`ifdef MC_CTRL_MUL_EN
   localparam logic [3:0] S_EXECM  = 4'd11;
`endif

   // Instruction class in Instr[27:26]
   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_BR    = 2'b10;

   // Data-processing cmd field Instr[24:21]
   localparam logic [3:0] CMD_AND  = 4'b0000;
   localparam logic [3:0] CMD_EOR  = 4'b0001;
   localparam logic [3:0] CMD_SUB  = 4'b0010;
   localparam logic [3:0] CMD_ADD  = 4'b0100;
   localparam logic [3:0] CMD_CMP  = 4'b1010;
   localparam logic [3:0] CMD_ORR  = 4'b1100;

   // Condition codes Instr[31:28]; 1111 never executes
   localparam logic [3:0] COND_EQ  = 4'd0;
   localparam logic [3:0] COND_NE  = 4'd1;
   localparam logic [3:0] COND_CS  = 4'd2;
   localparam logic [3:0] COND_CC  = 4'd3;
   localparam logic [3:0] COND_MI  = 4'd4;
   localparam logic [3:0] COND_PL  = 4'd5;
   localparam logic [3:0] COND_VS  = 4'd6;
   localparam logic [3:0] COND_VC  = 4'd7;
   localparam logic [3:0] COND_HI  = 4'd8;
   localparam logic [3:0] COND_LS  = 4'd9;
   localparam logic [3:0] COND_GE  = 4'd10;
   localparam logic [3:0] COND_LT  = 4'd11;
   localparam logic [3:0] COND_GT  = 4'd12;
   localparam logic [3:0] COND_LE  = 4'd13;
   localparam logic [3:0] COND_AL  = 4'd14;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_EOR = 3'b100,
      ALU_MUL = 3'b101
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    writes_rd;
      logic    arith;
   } dp_decode_t;

   // Unknown cmds run as ADD but never write a register or touch C/V
   function automatic dp_decode_t decode_dp(input logic [3:0] cmd);
      dp_decode_t d;
      d.alu_op    = ALU_ADD;
      d.writes_rd = 1'b0;
      d.arith     = 1'b0;
      case (cmd)
         CMD_ADD: begin d.alu_op = ALU_ADD; d.writes_rd = 1'b1; d.arith = 1'b1; end
         CMD_SUB: begin d.alu_op = ALU_SUB; d.writes_rd = 1'b1; d.arith = 1'b1; end
         CMD_AND: begin d.alu_op = ALU_AND; d.writes_rd = 1'b1; end
         CMD_ORR: begin d.alu_op = ALU_ORR; d.writes_rd = 1'b1; end
         CMD_EOR: begin d.alu_op = ALU_EOR; d.writes_rd = 1'b1; end
         CMD_CMP: begin d.alu_op = ALU_SUB; d.arith = 1'b1; end
         default: d.alu_op = ALU_ADD;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - controller/datapath signal bundle
interface mc_controller_if #(
   parameter int ALUCTL_W = 3,
   parameter int STATE_W  = 4
);
   logic [31:0]         Instr;
   logic [3:0]          ALUFlags;
   logic                PCWrite;
   logic                MemWrite;
   logic                RegWrite;
   logic                IRWrite;
   logic                AdrSrc;
   logic                ALUSrcA;
   logic [1:0]          RegSrc;
   logic [1:0]          ALUSrcB;
   logic [1:0]          ResultSrc;
   logic [1:0]          ImmSrc;
   logic [ALUCTL_W-1:0] ALUControl;
   logic                LinkWrite;
   logic [STATE_W-1:0]  State;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
      output RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl, LinkWrite, State
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
      input  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl, LinkWrite, State
   );
endinterface

// File: rtl/mc_condunit.sv
// rtl/mc_condunit.sv - NZCV flag register and per-instruction condition latch
module mc_condunit
   import mc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       cond_eval,
   input  logic [3:0] cond,
   input  logic       flag_wen,
   input  logic       flag_cv_wen,
   input  logic [3:0] alu_flags,
   output logic       cond_ex
);
   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q, cond_ex_d;
   logic       cond_pass;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags_q;
   assign cond_ex      = cond_ex_q;

   // Evaluate the condition field against the current flags
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         COND_EQ: cond_pass = z;
         COND_NE: cond_pass = ~z;
         COND_CS: cond_pass = c;
         COND_CC: cond_pass = ~c;
         COND_MI: cond_pass = n;
         COND_PL: cond_pass = ~n;
         COND_VS: cond_pass = v;
         COND_VC: cond_pass = ~v;
         COND_HI: cond_pass = c & ~z;
         COND_LS: cond_pass = ~c | z;
         COND_GE: cond_pass = (n == v);
         COND_LT: cond_pass = (n != v);
         COND_GT: cond_pass = ~z & (n == v);
         COND_LE: cond_pass = z | (n != v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Next flags: N/Z on any enabled update, C/V only for arithmetic ops
   always_comb begin
      flags_d   = flags_q;
      cond_ex_d = cond_ex_q;
      if (flag_wen) begin
         flags_d[3:2] = alu_flags[3:2];
      end
      if (flag_cv_wen) begin
         flags_d[1:0] = alu_flags[1:0];
      end
      if (cond_eval) begin
         cond_ex_d = cond_pass;
      end
   end

   // Flag and CondEx registers
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end
endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle controller FSM and decode (MC_CTRL_MUL_EN enables MUL via EXECM)
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int ALUCTL_W = 3,
   parameter int STATE_W  = 4
) (
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master bus
);
   logic [3:0]  state_q, state_d;
   logic [31:0] instr;
   logic [1:0]  op;
   logic [3:0]  cmd;
   logic        i_bit, s_bit, l_bit, bl_bit, rd_is_pc;
   logic        is_mul, dp_writes, in_exec, s_eff;
   logic        cond_ex, flag_wen, flag_cv_wen;
   logic        unused_instr;
   dp_decode_t  dp;
   alu_op_e     exec_op, alu_op;
   logic        pc_write, mem_write, reg_write, ir_write, link_write;
   logic        adr_src, alu_src_a;
   logic [1:0]  alu_src_b, result_src;

   assign instr    = bus.Instr;
   assign op       = instr[27:26];
   assign i_bit    = instr[25];
   assign cmd      = instr[24:21];
   assign bl_bit   = instr[24];
   assign s_bit    = instr[20];
   assign l_bit    = instr[20];
   assign rd_is_pc = (instr[15:12] == 4'hF);

`ifdef MC_CTRL_MUL_EN
   assign is_mul       = (op == OP_DP) && !i_bit && (cmd == CMD_AND) && (instr[7:4] == 4'b1001);
   assign in_exec      = (state_q == S_EXECR) || (state_q == S_EXECI) || (state_q == S_EXECM);
   assign unused_instr = ^{instr[19:16], instr[11:8], instr[3:0]};
`else
   assign is_mul       = 1'b0;
   assign in_exec      = (state_q == S_EXECR) || (state_q == S_EXECI);
   assign unused_instr = ^{instr[19:16], instr[11:8], instr[7:4], instr[3:0]};
`endif

   assign dp        = decode_dp(cmd);
   assign exec_op   = is_mul ? ALU_MUL : dp.alu_op;
   assign dp_writes = dp.writes_rd | is_mul;
   // CMP always sets flags regardless of the S bit
   assign s_eff       = s_bit | (cmd == CMD_CMP);
   assign flag_wen    = in_exec & cond_ex & s_eff;
   assign flag_cv_wen = flag_wen & dp.arith & ~is_mul;

   mc_condunit u_cond (
      .clk         (clk),
      .reset       (reset),
      .cond_eval   (state_q == S_DECODE),
      .cond        (instr[31:28]),
      .flag_wen    (flag_wen),
      .flag_cv_wen (flag_cv_wen),
      .alu_flags   (bus.ALUFlags),
      .cond_ex     (cond_ex)
   );

   // Next state: follow the instruction class through its path back to FETCH
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_DP: begin
                  state_d = i_bit ? S_EXECI : S_EXECR;
`ifdef MC_CTRL_MUL_EN
                  if (is_mul) state_d = S_EXECM;
`endif
               end
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = l_bit ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = S_FETCH;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
`ifdef MC_CTRL_MUL_EN
         S_EXECM:  state_d = S_ALUWB;
`endif
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = bl_bit ? S_LINK : S_FETCH;
         S_LINK:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // Per-state datapath controls; writes after DECODE are gated by CondEx
   always_comb begin
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      ir_write   = 1'b0;
      link_write = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_op     = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_MEMADR: alu_src_b = 2'b01;
         S_MEMRD:  adr_src   = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = cond_ex & ~rd_is_pc;
            pc_write   = cond_ex & rd_is_pc;
         end
         S_MEMWR: begin
            adr_src   = 1'b1;
            mem_write = cond_ex;
         end
         S_EXECR: alu_op = exec_op;
         S_EXECI: begin
            alu_src_b = 2'b01;
            alu_op    = exec_op;
         end
`ifdef MC_CTRL_MUL_EN
         S_EXECM: alu_op = exec_op;
`endif
         S_ALUWB: begin
            reg_write = cond_ex & dp_writes & ~rd_is_pc;
            pc_write  = cond_ex & dp_writes & rd_is_pc;
         end
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = cond_ex;
         end
         S_LINK: begin
            // 11 selects the return address the datapath captured before BRANCH
            result_src = 2'b11;
            link_write = 1'b1;
            reg_write  = cond_ex;
         end
         default: alu_op = ALU_ADD;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes are forced low while reset is held so an aborted instruction writes nothing
   assign bus.PCWrite    = pc_write & ~reset;
   assign bus.MemWrite   = mem_write & ~reset;
   assign bus.RegWrite   = reg_write & ~reset;
   assign bus.IRWrite    = ir_write & ~reset;
   assign bus.LinkWrite  = link_write & ~reset;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
   assign bus.ImmSrc     = op;
   assign bus.ALUControl = ALUCTL_W'(alu_op);
   assign bus.State      = STATE_W'(state_q);
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller (MC_CTRL_MUL_EN selects the multiply variant)
module tb_mc_controller;
   import mc_controller_pkg::*;

   localparam int ALUCTL_W = 3;
   localparam int STATE_W  = 4;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_write;
      logic       mem_write;
      logic       reg_write;
      logic       ir_write;
      logic       link_write;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] reg_src;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] imm_src;
      logic [2:0] alu_ctl;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_controller_if #(.ALUCTL_W(ALUCTL_W), .STATE_W(STATE_W)) bus ();

   mc_controller #(.ALUCTL_W(ALUCTL_W), .STATE_W(STATE_W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   obs_t  exp_q[$];
   obs_t  mask_q[$];
   string tag_q[$];
   int    checks = 0;
   int    failures = 0;
   logic [3:0] m_flags = 4'b0000;
   logic       force_en = 1'b0;
   logic [3:0] force_flags = 4'b0000;
   logic [3:0] cmd_tab [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010};

   function automatic obs_t sample();
      obs_t a;
      a.state      = bus.State[3:0];
      a.pc_write   = bus.PCWrite;
      a.mem_write  = bus.MemWrite;
      a.reg_write  = bus.RegWrite;
      a.ir_write   = bus.IRWrite;
      a.link_write = bus.LinkWrite;
      a.adr_src    = bus.AdrSrc;
      a.alu_src_a  = bus.ALUSrcA;
      a.reg_src    = bus.RegSrc;
      a.alu_src_b  = bus.ALUSrcB;
      a.result_src = bus.ResultSrc;
      a.imm_src    = bus.ImmSrc;
      a.alu_ctl    = bus.ALUControl[2:0];
      return a;
   endfunction

   // Monitor: compare whatever the DUT shows against the oldest expectation
   always @(negedge clk) begin : monitor
      obs_t a, e, m;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         m = mask_q.pop_front();
         t = tag_q.pop_front();
         a = sample();
         checks++;
         if (((a ^ e) & m) != '0) begin
            failures++;
            $display("FAIL %s: got %h required %h (mask %h)", t, a, e, m);
         end
      end
   end

   // ARM condition semantics: pairs of codes share a base test, odd codes invert it
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      return c[0] ? ~base : base;
   endfunction

   function automatic logic [2:0] alu_code(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return 3'b000;
         4'b0010: return 3'b001;
         4'b0000: return 3'b010;
         4'b1100: return 3'b011;
         4'b0001: return 3'b100;
         4'b1010: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic obs_t blank(input logic [3:0] st, input logic [31:0] ins);
      obs_t o = '0;
      o.state   = st;
      o.reg_src = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
      o.imm_src = ins[27:26];
      return o;
   endfunction

   task automatic issue(input obs_t e, input obs_t m, input string tag, output logic [3:0] fl);
      fl = force_en ? force_flags : 4'($urandom);
      bus.ALUFlags = fl;
      exp_q.push_back(e);
      mask_q.push_back(m);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   // One reset cycle: only the write strobes are specified while reset is high
   task automatic issue_reset(input string tag);
      obs_t m = '0;
      logic [3:0] fl;
      m.pc_write = 1'b1; m.mem_write = 1'b1; m.reg_write = 1'b1;
      m.ir_write = 1'b1; m.link_write = 1'b1;
      reset = 1'b1;
      issue('0, m, tag, fl);
      reset = 1'b0;
      m_flags = 4'b0000;
   endtask

   // Build the expected cycle-by-cycle response of one instruction, optionally reset at step abort_at
   task automatic run_instr(input logic [31:0] ins, input int abort_at);
      obs_t seq[$];
      obs_t o;
      logic [1:0] op;
      logic [3:0] cmd, fl;
      logic ok, mul, wr, rd_pc, s_eff, arith;
      int exec_idx;
      op    = ins[27:26];
      cmd   = ins[24:21];
      rd_pc = (ins[15:12] == 4'hF);
      ok    = cond_holds(ins[31:28], m_flags);
      exec_idx = -1;
`ifdef MC_CTRL_MUL_EN
      mul = (op == 2'b00) && !ins[25] && (cmd == 4'b0000) && (ins[7:4] == 4'b1001);
`else
      mul = 1'b0;
`endif
      s_eff = ins[20] || (cmd == 4'b1010);
      arith = !mul && (cmd inside {4'b0100, 4'b0010, 4'b1010});
      o = blank(S_FETCH, ins);
      o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_a = 1'b1;
      o.alu_src_b = 2'b10; o.result_src = 2'b10;
      seq.push_back(o);
      o = blank(S_DECODE, ins);
      o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
      seq.push_back(o);
      case (op)
         2'b00: begin
            exec_idx = 2;
            o = blank(ins[25] ? S_EXECI : S_EXECR, ins);
            o.alu_src_b = ins[25] ? 2'b01 : 2'b00;
            o.alu_ctl = alu_code(cmd);
`ifdef MC_CTRL_MUL_EN
            if (mul) begin
               o = blank(S_EXECM, ins);
               o.alu_ctl = 3'b101;
            end
`endif
            seq.push_back(o);
            wr = mul || (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001});
            o = blank(S_ALUWB, ins);
            o.reg_write = ok && wr && !rd_pc;
            o.pc_write  = ok && wr && rd_pc;
            seq.push_back(o);
         end
         2'b01: begin
            o = blank(S_MEMADR, ins); o.alu_src_b = 2'b01; seq.push_back(o);
            if (ins[20]) begin
               o = blank(S_MEMRD, ins); o.adr_src = 1'b1; seq.push_back(o);
               o = blank(S_MEMWB, ins); o.result_src = 2'b01;
               o.reg_write = ok && !rd_pc; o.pc_write = ok && rd_pc;
               seq.push_back(o);
            end else begin
               o = blank(S_MEMWR, ins); o.adr_src = 1'b1; o.mem_write = ok; seq.push_back(o);
            end
         end
         2'b10: begin
            o = blank(S_BRANCH, ins);
            o.alu_src_b = 2'b01; o.result_src = 2'b10; o.pc_write = ok;
            seq.push_back(o);
            if (ins[24]) begin
               o = blank(S_LINK, ins);
               o.result_src = 2'b11; o.link_write = 1'b1; o.reg_write = ok;
               seq.push_back(o);
            end
         end
         default: ;
      endcase
      bus.Instr = ins;
      for (int i = 0; i < seq.size(); i++) begin
         if (i == abort_at) begin
            issue_reset($sformatf("ins=%08h reset_at=%0d", ins, i));
            return;
         end
         issue(seq[i], '1, $sformatf("ins=%08h step=%0d", ins, i), fl);
         if (i == exec_idx && ok && s_eff) begin
            m_flags[3:2] = fl[3:2];
            if (arith) m_flags[1:0] = fl[1:0];
         end
      end
   endtask

   task automatic check_flags(input string tag);
      checks++;
      if (u_dut.u_cond.flags_q !== m_flags) begin
         failures++;
         $display("FAIL flags %s: got %b required %b", tag, u_dut.u_cond.flags_q, m_flags);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 2) != 0) r[31:28] = 4'hE;
      if ($urandom_range(0, 1) != 0) r[24:21] = cmd_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) r[15:12] = 4'hF;
      if ($urandom_range(0, 5) == 0) begin
         r[27:21] = 7'b0000000;
         r[7:4]   = 4'b1001;
      end
      return r;
   endfunction

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog: time %0t required below 200000", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : stimulus
      logic [31:0] ins;
      int ab;
      reset = 1'b1;
      bus.Instr = 32'h0;
      bus.ALUFlags = 4'h0;
      @(posedge clk);
      #1;
      issue_reset("reset0");
      issue_reset("reset1");
      check_flags("after_reset");

      run_instr(32'hE0821003, -1);
      check_flags("add");

      force_en = 1'b1; force_flags = 4'b0110;
      run_instr(32'hE1510001, -1);
      force_en = 1'b0;
      checks++;
      if (u_dut.u_cond.flags_q !== 4'b0110) begin
         failures++;
         $display("FAIL cmp_flags: got %b required 0110", u_dut.u_cond.flags_q);
      end

      force_en = 1'b1; force_flags = 4'b0000;
      run_instr(32'hE1510001, -1);
      force_en = 1'b0;
      run_instr(32'h0A000004, -1);
      force_en = 1'b1; force_flags = 4'b0100;
      run_instr(32'hE1510001, -1);
      force_en = 1'b0;
      run_instr(32'h0A000004, -1);
      check_flags("beq");

      run_instr(32'hEB000004, -1);
      run_instr(32'hE5910000, -1);
      run_instr(32'hE5810000, -1);
      run_instr(32'hE591F000, -1);
      run_instr(32'hEC000000, -1);
      run_instr(32'hE0000291, -1);
      check_flags("mul_or_and");
`ifdef MC_CTRL_MUL_EN
      run_instr(32'hE0000291, 2);
      check_flags("mul_abort");
`endif
      run_instr(32'hE0821003, 3);
      check_flags("aluwb_abort");

      for (int n = 0; n < 300; n++) begin
         ins = rand_instr();
         ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(ins, ab);
         check_flags($sformatf("rand%0d", n));
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
